// File: rtl/ethernet_pkg.sv
// Shared Ethernet constants and frame status type used by the RX FCS checker
// and the TX FCS generator.
package ethernet_pkg;

    localparam logic [31:0] eth_crc32_poly_gp    = 32'hEDB8_8320;
    localparam logic [31:0] eth_crc32_init_gp    = 32'hFFFF_FFFF;
    localparam logic [31:0] eth_crc32_residue_gp = 32'hDEBB_20E3;
    localparam int          eth_fcs_bytes_gp     = 4;

    typedef enum logic [1:0] {
        e_fcs_none    = 2'd0,
        e_fcs_ok      = 2'd1,
        e_fcs_crc_err = 2'd2,
        e_fcs_len_err = 2'd3
    } fcs_status_e;

endpackage

// File: rtl/ethernet_crc32_byte.sv
// One-byte step of the reflected Ethernet CRC-32 (LSB of data_i first).
module ethernet_crc32_byte
    import ethernet_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] crc_s;

    // Eight serial LFSR shifts, unrolled into one combinational step.
    always_comb begin
        crc_s = crc_i;
        for (int i = 0; i < 8; i++) begin
            crc_s = {1'b0, crc_s[31:1]} ^ (eth_crc32_poly_gp & {32{crc_s[0] ^ data_i[i]}});
        end
        crc_o = crc_s;
    end

endmodule

// File: rtl/ethernet_rx_fcs_checker.sv
// Ethernet RX stage: strips the 4-byte FCS through a 4-byte delay line, checks
// CRC-32 and frame length, and flags bad frames on their last output byte.
module ethernet_rx_fcs_checker
    import ethernet_pkg::*;
#(
    parameter int min_len_p   = 64,
    parameter int max_len_p   = 1518,
    parameter int len_width_p = 11
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] data_i,
    input  logic       v_i,
    input  logic       last_i,
    input  logic       error_i,
    output logic       ready_and_o,
    output logic [7:0] data_o,
    output logic       v_o,
    output logic       last_o,
    output logic       error_o,
    input  logic       ready_and_i,
    output logic       frame_ok_o,
    output logic       crc_err_o,
    output logic       len_err_o
);

    localparam logic [2:0]             occ_full_lp = 3'(eth_fcs_bytes_gp);
    localparam logic [len_width_p-1:0] min_len_lp  = len_width_p'(min_len_p);
    localparam logic [len_width_p-1:0] max_len_lp  = len_width_p'(max_len_p);

    logic [3:0][7:0]         sr_q, sr_d;
    logic [2:0]              occ_q, occ_d;
    logic [31:0]             crc_q, crc_d;
    logic [len_width_p-1:0]  len_q, len_d;
    logic                    err_q, err_d;
    fcs_status_e             status_q, status_d;

    logic                    full_s;
    logic                    accept_s;
    logic [31:0]             crc_next_s;
    logic [len_width_p-1:0]  len_next_s;
    logic                    crc_bad_s;
    logic                    len_bad_s;

    ethernet_crc32_byte crc_step (
        .crc_i  (crc_q),
        .data_i (data_i),
        .crc_o  (crc_next_s)
    );

    // Handshake and pass-through outputs; once full, in->out is combinational.
    always_comb begin
        full_s      = (occ_q == occ_full_lp);
        ready_and_o = reset_i | ~full_s | ready_and_i;
        accept_s    = v_i & ready_and_o & ~reset_i;
        v_o         = v_i & full_s & ~reset_i;
        data_o      = sr_q[0];
        last_o      = v_o & last_i;
        len_next_s  = (&len_q) ? len_q : len_q + {{(len_width_p-1){1'b0}}, 1'b1};
        len_bad_s   = (len_next_s < min_len_lp) | (len_next_s > max_len_lp);
        crc_bad_s   = (crc_next_s != eth_crc32_residue_gp);
        error_o     = last_o & (crc_bad_s | len_bad_s | err_q | error_i);
    end

    // Next-state for delay line, CRC, length and sticky PHY error.
    always_comb begin
        sr_d  = sr_q;
        occ_d = occ_q;
        crc_d = crc_q;
        len_d = len_q;
        err_d = err_q;
        if (accept_s) begin
            if (last_i) begin
                occ_d = 3'd0;
                crc_d = eth_crc32_init_gp;
                len_d = '0;
                err_d = 1'b0;
            end else begin
                crc_d = crc_next_s;
                len_d = len_next_s;
                err_d = err_q | error_i;
                if (full_s) begin
                    sr_d = {data_i, sr_q[3], sr_q[2], sr_q[1]};
                end else begin
                    sr_d[occ_q[1:0]] = data_i;
                    occ_d            = occ_q + 3'd1;
                end
            end
        end else begin
            occ_d = occ_q;
        end
    end

    // Frame verdict; length outranks CRC, and a PHY error reports as CRC.
    always_comb begin
        if (!(accept_s & last_i)) begin
            status_d = e_fcs_none;
        end else if (len_bad_s) begin
            status_d = e_fcs_len_err;
        end else if (crc_bad_s | err_q | error_i) begin
            status_d = e_fcs_crc_err;
        end else begin
            status_d = e_fcs_ok;
        end
    end

    // State and verdict registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sr_q     <= '0;
            occ_q    <= 3'd0;
            crc_q    <= eth_crc32_init_gp;
            len_q    <= '0;
            err_q    <= 1'b0;
            status_q <= e_fcs_none;
        end else begin
            sr_q     <= sr_d;
            occ_q    <= occ_d;
            crc_q    <= crc_d;
            len_q    <= len_d;
            err_q    <= err_d;
            status_q <= status_d;
        end
    end

    // Decode the registered verdict into one-hot pulses.
    always_comb begin
        frame_ok_o = 1'b0;
        crc_err_o  = 1'b0;
        len_err_o  = 1'b0;
        case (status_q)
            e_fcs_ok:      frame_ok_o = 1'b1;
            e_fcs_crc_err: crc_err_o  = 1'b1;
            e_fcs_len_err: len_err_o  = 1'b1;
            default:       frame_ok_o = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_ethernet_rx_fcs_checker.sv
// Self-checking bench for ethernet_rx_fcs_checker: random frames against a
// frame-level model (CRC recomputed over payload and compared with the FCS field).
module tb_ethernet_rx_fcs_checker;

    logic       clk = 1'b0;
    logic       reset_i, v_i, last_i, error_i, ready_and_i;
    logic [7:0] data_i;
    logic       ready_and_o, v_o, last_o, error_o;
    logic [7:0] data_o;
    logic       frame_ok_o, crc_err_o, len_err_o;

    ethernet_rx_fcs_checker dut (
        .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .v_i(v_i), .last_i(last_i),
        .error_i(error_i), .ready_and_o(ready_and_o), .data_o(data_o), .v_o(v_o),
        .last_o(last_o), .error_o(error_o), .ready_and_i(ready_and_i),
        .frame_ok_o(frame_ok_o), .crc_err_o(crc_err_o), .len_err_o(len_err_o)
    );

    always #5 clk = ~clk;

    logic [7:0] frame_b [0:2047];
    logic       frame_e [0:2047];
    logic [9:0] obs_q[$];
    logic [9:0] exp_q[$];
    int cmp_cnt = 0, fail_cnt = 0;
    int ok_cnt = 0, crc_cnt = 0, len_cnt = 0, proto_bad = 0;
    int exp_ok = 0, exp_crc = 0, exp_len = 0;
    int acc_in_frame = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference CRC-32 of the first n bytes of frame_b, final complement applied.
    function automatic logic [31:0] crc32(input int n);
        logic [31:0] c = 32'hFFFF_FFFF;
        logic        fb;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ frame_b[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return ~c;
    endfunction

    // Monitor: records output transfers and pulses, checks handshake rules each cycle.
    always @(negedge clk) begin
        logic exp_rdy, exp_v;
        exp_rdy = reset_i || !(acc_in_frame >= 4 && !ready_and_i);
        exp_v   = !reset_i && v_i && (acc_in_frame >= 4);
        if (ready_and_o !== exp_rdy) proto_bad++;
        if (v_o !== exp_v) proto_bad++;
        if (last_o !== (exp_v && last_i)) proto_bad++;
        if (int'(frame_ok_o) + int'(crc_err_o) + int'(len_err_o) > 1) proto_bad++;
        ok_cnt  += int'(frame_ok_o);
        crc_cnt += int'(crc_err_o);
        len_cnt += int'(len_err_o);
        if (!reset_i && v_o && ready_and_i) obs_q.push_back({last_o, error_o, data_o});
        if (reset_i) acc_in_frame = 0;
        else if (v_i && ready_and_o) acc_in_frame = last_i ? 0 : acc_in_frame + 1;
    end

    task automatic idle();
        v_i = 1'b0; last_i = 1'b0; error_i = 1'b0; ready_and_i = 1'b1; data_i = 8'h00;
    endtask

    task automatic drive_byte(input logic [7:0] d, input logic lst, input logic er, input bit rnd);
        bit done  = 0;
        int guard = 0;
        while (!done) begin
            v_i         = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            ready_and_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            data_i      = v_i ? d : 8'($urandom);
            last_i      = v_i ? lst : 1'($urandom_range(0, 1));
            error_i     = v_i ? er : 1'($urandom_range(0, 1));
            @(negedge clk);
            done = v_i && ready_and_o;
            @(posedge clk); #1;
            guard++;
            if (!done && guard > 200) begin
                chk("accept_timeout", 32'(guard), 32'd0);
                done = 1;
            end
        end
    endtask

    task automatic send_frame(input int n, input bit rnd, input int stop);
        int cnt = (stop >= 0) ? stop : n;
        for (int i = 0; i < cnt; i++) drive_byte(frame_b[i], i == n - 1, frame_e[i], rnd);
        idle();
    endtask

    task automatic build_good(input int n);
        logic [31:0] c;
        for (int i = 0; i < n; i++) begin
            frame_b[i] = 8'($urandom);
            frame_e[i] = 1'b0;
        end
        if (n > 4) begin
            c = crc32(n - 4);
            frame_b[n-4] = c[7:0];
            frame_b[n-3] = c[15:8];
            frame_b[n-2] = c[23:16];
            frame_b[n-1] = c[31:24];
        end
    endtask

    // Model: payload is everything but the last 4 bytes; verdict from length, FCS field, PHY errors.
    task automatic add_expect(input int n);
        logic bad_len, bad_crc, phy, err;
        if (n <= 4) begin
            exp_len++;
            return;
        end
        bad_len = (n < 64) || (n > 1518);
        bad_crc = crc32(n - 4) != {frame_b[n-1], frame_b[n-2], frame_b[n-3], frame_b[n-4]};
        phy = 1'b0;
        for (int i = 0; i < n; i++) phy |= frame_e[i];
        err = bad_len | bad_crc | phy;
        for (int i = 0; i < n - 4; i++)
            exp_q.push_back({(i == n - 5) ? 1'b1 : 1'b0, (i == n - 5) ? err : 1'b0, frame_b[i]});
        if (bad_len) exp_len++;
        else if (bad_crc || phy) exp_crc++;
        else exp_ok++;
    endtask

    task automatic check_group(input string tag);
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_out_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_byte"}, 32'(obs_q[i]), 32'(exp_q[i]));
        chk({tag, "_frame_ok"}, 32'(ok_cnt), 32'(exp_ok));
        chk({tag, "_crc_err"}, 32'(crc_cnt), 32'(exp_crc));
        chk({tag, "_len_err"}, 32'(len_cnt), 32'(exp_len));
        chk({tag, "_protocol"}, 32'(proto_bad), 32'd0);
        obs_q.delete(); exp_q.delete();
        ok_cnt = 0; crc_cnt = 0; len_cnt = 0; proto_bad = 0;
        exp_ok = 0; exp_crc = 0; exp_len = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        idle();
        reset_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", 32'(ready_and_o), 32'd1);
        chk("reset_v_o", 32'(v_o), 32'd0);
        @(posedge clk); #1;
        reset_i = 1'b0;
        @(negedge clk);
        chk("post_reset_pulses", {29'd0, frame_ok_o, crc_err_o, len_err_o}, 32'd0);
        chk("post_reset_last", 32'(last_o), 32'd0);
        @(posedge clk); #1;
        obs_q.delete(); ok_cnt = 0; crc_cnt = 0; len_cnt = 0; proto_bad = 0;

        build_good(64); add_expect(64); send_frame(64, 0, -1); check_group("good64");

        build_good(64); frame_b[10] ^= 8'h01; add_expect(64); send_frame(64, 0, -1);
        check_group("crc_flip");

        build_good(63); add_expect(63); send_frame(63, 0, -1); check_group("len63");
        build_good(1519); add_expect(1519); send_frame(1519, 0, -1); check_group("len1519");

        build_good(3); add_expect(3); send_frame(3, 0, -1);
        build_good(64); add_expect(64); send_frame(64, 0, -1); check_group("runt3");

        for (int k = 0; k < 8; k++) begin
            build_good(64); add_expect(64); send_frame(64, 1, -1);
        end
        check_group("b2b_random");

        build_good(64); frame_e[19] = 1'b1; add_expect(64); send_frame(64, 0, -1);
        check_group("phy_err");

        build_good(64); send_frame(64, 0, 30);
        for (int i = 0; i < 26; i++) exp_q.push_back({2'b00, frame_b[i]});
        v_i = 1'b1; last_i = 1'b1; data_i = 8'h5A; reset_i = 1'b1;
        @(negedge clk);
        chk("midreset_v_o", 32'(v_o), 32'd0);
        chk("midreset_ready", 32'(ready_and_o), 32'd1);
        @(posedge clk); #1;
        reset_i = 1'b0; idle();
        check_group("mid_reset");
        build_good(64); add_expect(64); send_frame(64, 0, -1); check_group("after_reset");

        for (int k = 0; k < 6; k++) begin
            n = $urandom_range(1, 90);
            build_good(n);
            if ($urandom_range(0, 2) == 0) frame_b[$urandom_range(0, n - 1)] ^= 8'h10;
            if ($urandom_range(0, 3) == 0) frame_e[$urandom_range(0, n - 1)] = 1'b1;
            add_expect(n); send_frame(n, 1, -1);
        end
        check_group("random_mix");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
